// File: rtl/divider_exe_pkg.sv
// Shared types and constants for the RV32M DIV execution pipe (divider_exe).
package divider_exe_pkg;

    localparam int XLEN        = 32;
    localparam int REG_WIDTH   = 5;
    localparam int DIV_LATENCY = 34;

    // Bit0 selects unsigned, bit1 selects remainder.
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_t;

    typedef struct packed {
        div_op_t              div_control;
        logic [REG_WIDTH-1:0] rd;
        logic [XLEN-1:0]      rs1;
        logic [XLEN-1:0]      rs2;
    } ix_div_inf_t;

    typedef struct packed {
        logic [REG_WIDTH-1:0] rd;
        logic [XLEN-1:0]      wr_data;
    } div_wb_inf_t;

    function automatic logic is_signed_op(input div_op_t op);
        return !op[0];
    endfunction

endpackage

// File: rtl/div_sign_fixup.sv
// Combinational sign handling for the divider: operand magnitudes and result signs on the
// way in, conditional negation plus divide-by-zero forcing on the way out.
module div_sign_fixup
    import divider_exe_pkg::*;
(
    input  logic            pre_signed,
    input  logic [XLEN-1:0] pre_rs1,
    input  logic [XLEN-1:0] pre_rs2,
    output logic [XLEN-1:0] pre_abs_rs1,
    output logic [XLEN-1:0] pre_abs_rs2,
    output logic            pre_neg_quo,
    output logic            pre_neg_rem,
    output logic            pre_div_by_zero,
    input  logic            fix_rem_sel,
    input  logic [XLEN-1:0] fix_quotient,
    input  logic [XLEN-1:0] fix_remainder,
    input  logic [XLEN-1:0] fix_rs1,
    input  logic            fix_neg_quo,
    input  logic            fix_neg_rem,
    input  logic            fix_div_by_zero,
    output logic [XLEN-1:0] fix_result
);

    function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // 0x80000000 negates to itself, which read as unsigned is exactly 2^31.
    assign pre_abs_rs1     = cond_neg(pre_signed && pre_rs1[XLEN-1], pre_rs1);
    assign pre_abs_rs2     = cond_neg(pre_signed && pre_rs2[XLEN-1], pre_rs2);
    assign pre_neg_quo     = pre_signed && (pre_rs1[XLEN-1] ^ pre_rs2[XLEN-1]);
    assign pre_neg_rem     = pre_signed && pre_rs1[XLEN-1];
    assign pre_div_by_zero = (pre_rs2 == '0);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        fix_result = '0;
        if (fix_rem_sel) begin
            fix_result = fix_div_by_zero ? fix_rs1 : cond_neg(fix_neg_rem, fix_remainder);
        end else begin
            fix_result = fix_div_by_zero ? '1 : cond_neg(fix_neg_quo, fix_quotient);
        end
    end

endmodule

// File: rtl/divider_exe.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with a valid/ready result port.
// Optional macro DIV_EARLY_OUT_EN: resolve divide-by-zero and |rs1| < |rs2| in one cycle.
module divider_exe
    import divider_exe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ix_div_valid,
    input  ix_div_inf_t ix_div_inf,
    input  logic        wb_do_branch,
    output logic        div_wb_valid,
    output div_wb_inf_t div_wb_inf,
    input  logic        wb_div_ready,
    output logic        div_ix_done
);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIXUP, S_DONE} state_t;

    state_t state, state_nxt;

    logic [5:0]           count;
    logic [XLEN-1:0]      rem_q;
    logic [XLEN-1:0]      quo_q;
    logic [XLEN-1:0]      divisor_q;
    logic [XLEN-1:0]      rs1_q;
    logic [REG_WIDTH-1:0] rd_q;
    logic                 rem_sel_q;
    logic                 neg_quo_q;
    logic                 neg_rem_q;
    logic                 dbz_q;

    logic                 accept;
    logic                 early_out;
    logic                 load_result;
    logic                 use_pre;

    logic                 pre_signed;
    logic [XLEN-1:0]      abs_rs1;
    logic [XLEN-1:0]      abs_rs2;
    logic                 pre_neg_quo;
    logic                 pre_neg_rem;
    logic                 pre_dbz;

    logic [XLEN:0]        trial_shift;
    logic [XLEN:0]        trial_diff;
    logic                 trial_ge;

    logic                 fix_rem_sel;
    logic [XLEN-1:0]      fix_quotient;
    logic [XLEN-1:0]      fix_remainder;
    logic [XLEN-1:0]      fix_rs1;
    logic                 fix_neg_quo;
    logic                 fix_neg_rem;
    logic                 fix_dbz;
    logic [XLEN-1:0]      fix_result;
    logic [REG_WIDTH-1:0] result_rd;

    assign accept     = (state == S_IDLE) && ix_div_valid && !wb_do_branch;
    assign pre_signed = is_signed_op(ix_div_inf.div_control);

`ifdef DIV_EARLY_OUT_EN
    // Trivial cases resolve straight from the operands while still in IDLE.
    assign early_out = pre_dbz || (abs_rs1 < abs_rs2);
    assign use_pre   = (state == S_IDLE);
`else
    assign early_out = 1'b0;
    assign use_pre   = 1'b0;
`endif

    // Early-out reuses the fixup path with quotient 0 and remainder |rs1|.
    assign fix_rem_sel   = use_pre ? ix_div_inf.div_control[1] : rem_sel_q;
    assign fix_quotient  = use_pre ? '0                        : quo_q;
    assign fix_remainder = use_pre ? abs_rs1                   : rem_q;
    assign fix_rs1       = use_pre ? ix_div_inf.rs1            : rs1_q;
    assign fix_neg_quo   = use_pre ? pre_neg_quo               : neg_quo_q;
    assign fix_neg_rem   = use_pre ? pre_neg_rem               : neg_rem_q;
    assign fix_dbz       = use_pre ? pre_dbz                   : dbz_q;
    assign result_rd     = use_pre ? ix_div_inf.rd             : rd_q;

    div_sign_fixup u_sign_fixup (
        .pre_signed      (pre_signed),
        .pre_rs1         (ix_div_inf.rs1),
        .pre_rs2         (ix_div_inf.rs2),
        .pre_abs_rs1     (abs_rs1),
        .pre_abs_rs2     (abs_rs2),
        .pre_neg_quo     (pre_neg_quo),
        .pre_neg_rem     (pre_neg_rem),
        .pre_div_by_zero (pre_dbz),
        .fix_rem_sel     (fix_rem_sel),
        .fix_quotient    (fix_quotient),
        .fix_remainder   (fix_remainder),
        .fix_rs1         (fix_rs1),
        .fix_neg_quo     (fix_neg_quo),
        .fix_neg_rem     (fix_neg_rem),
        .fix_div_by_zero (fix_dbz),
        .fix_result      (fix_result)
    );

    // Partial remainder never exceeds the divisor, so a 33-bit trial is enough for unsigned 2^32-1.
    assign trial_shift = {rem_q, quo_q[XLEN-1]};
    assign trial_diff  = trial_shift - {1'b0, divisor_q};
    assign trial_ge    = !trial_diff[XLEN];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        div_ix_done = 1'b0;
        if (wb_do_branch) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (ix_div_valid) state_nxt = early_out ? S_DONE : S_ITER;
                S_ITER:  if (count == 6'd31) state_nxt = S_FIXUP;
                S_FIXUP: state_nxt = S_DONE;
                S_DONE: begin
                    if (wb_div_ready) begin
                        state_nxt   = S_IDLE;
                        div_ix_done = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign load_result = (state_nxt == S_DONE) && (state != S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            div_wb_valid <= 1'b0;
        end else begin
            if (wb_do_branch || div_ix_done) begin
                div_wb_valid <= 1'b0;
            end else if (load_result) begin
                div_wb_valid <= 1'b1;
            end
            if (accept) begin
                count <= '0;
            end else if (state == S_ITER) begin
                count <= count + 1'b1;
            end
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded before being observed.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_q      <= ix_div_inf.rd;
            rem_sel_q <= ix_div_inf.div_control[1];
            rs1_q     <= ix_div_inf.rs1;
            quo_q     <= abs_rs1;
            divisor_q <= abs_rs2;
            rem_q     <= '0;
            neg_quo_q <= pre_neg_quo;
            neg_rem_q <= pre_neg_rem;
            dbz_q     <= pre_dbz;
        end else if (state == S_ITER) begin
            rem_q <= trial_ge ? trial_diff[XLEN-1:0] : trial_shift[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], trial_ge};
        end
        if (load_result) begin
            div_wb_inf.rd      <= result_rd;
            div_wb_inf.wr_data <= fix_result;
        end
    end

endmodule

// File: doc/divider_exe.md
# divider_exe

Iterative radix-2 integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It is the DIV execution pipe: it accepts one operation at a time from instruction issue and computes one quotient bit per cycle. It hands the result to write-back through a valid/ready handshake. It pulses `div_ix_done` so issue can release its single-outstanding-divide interlock. In-flight work is discarded on a branch flush.

## Interface
- `XLEN`, 32: operand/result width.
- `REG_WIDTH`, 5: destination register index width (from shared package).
- `clk`  in  1  clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `ix_div_valid`  in  1  new operation presented this cycle.
- `ix_div_inf`  in  struct  `div_control` (2), `rd` (REG_WIDTH), `rs1` (XLEN), `rs2` (XLEN).
- `wb_do_branch`  in  1  pipeline flush; kills any operation held here.
- `div_wb_valid`  out  1  result available to write-back.
- `div_wb_inf`  out  struct  `rd`, `wr_data` (XLEN).
- `wb_div_ready`  in  1  write-back accepts the result this cycle.
- `div_ix_done`  out  1  one-cycle pulse when the result is accepted (`div_wb_valid && wb_div_ready`).

## Operation
- `div_control` encoding: 2'b00 DIV, 2'b01 DIVU, 2'b10 REM, 2'b11 REMU. Bit0 selects unsigned; bit1 selects remainder.
- FSM states: IDLE, ITER, FIXUP, DONE.
- **IDLE**
  - `ix_div_valid && !wb_do_branch`: latch `rd` and op.
  - Latch |rs1| and |rs2|; absolute values apply only for signed ops, and 0x80000000 maps to 2^31 unsigned.
  - Record quotient sign = sign(rs1) XOR sign(rs2) and remainder sign = sign(rs1), both signed ops only.
  - Clear the 6-bit counter and go to ITER.
- **ITER** (32 cycles, restoring division)
  - Each cycle: shift the {rem, dividend} pair left by one.
  - Compute a 33-bit trial subtraction rem − divisor.
  - If non-negative, keep the difference and set quotient bit 1; otherwise restore and set bit 0.
  - After count 31, go to FIXUP.
- **FIXUP**
  - Apply sign negation to the quotient or remainder.
  - Divide by zero: quotient = 0xFFFFFFFF for both signed and unsigned (forced, never negated); remainder = original rs1.
  - Overflow 0x80000000 / −1 needs no special case: it falls out as quotient 0x80000000, remainder 0.
  - Register `div_wb_inf` and set `div_wb_valid`; go to DONE.
- **DONE**
  - Hold `div_wb_valid` and `div_wb_inf` stable until `wb_div_ready`.
  - On the accept cycle, `div_ix_done`=1 and the next state is IDLE.
- Flush: `wb_do_branch` in any state forces IDLE next cycle.
  - Clears `div_wb_valid`.
  - Suppresses `div_ix_done`, even if `wb_div_ready` is high the same cycle.
  - `ix_div_valid` coinciding with `wb_do_branch` is dropped.
- `ix_div_valid` outside IDLE is a protocol error. It is ignored, and the bench asserts it never occurs.

## Timing
- Reset values: state IDLE, `div_wb_valid`=0, `div_ix_done`=0, counter 0. `div_wb_inf` is don't-care.
- Operation sampled in cycle T:
  - ITER during T+1..T+32.
  - FIXUP in T+33.
  - `div_wb_valid` first high in T+34.
- With `wb_div_ready` high at T+34, `div_ix_done` pulses in T+34 and IDLE is reached in T+35.
- Each cycle of `wb_div_ready` low delays the done pulse by one cycle.
- Earliest next accept: T+35. In practice issue re-arms later.
- `div_ix_done` is combinational from state and `wb_div_ready`; all other outputs are registered.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - In IDLE, on accept, detect divisor == 0 or |rs1| < |rs2|.
  - Compute the result directly and jump to DONE: divide-by-zero values as above; otherwise quotient 0, remainder rs1.
  - `div_wb_valid` is then high in T+1.
- Undefined: every operation takes the fixed 34-cycle latency. Results are identical either way.

## Structure
- Shared package holds:
  - the `div_op_t` enum (encodings above);
  - the `ix_div_inf_t` and `div_wb_inf_t` structs;
  - the `DIV_LATENCY` = 34 constant.
- FSM state enum stays local.
- One natural sub-module, `div_sign_fixup`: combinational abs/negate plus divide-by-zero selection, shared by the IDLE pre-processing and FIXUP.

## Test plan
- DIVU 100 / 7, ready tied high → `wr_data`=14 and `div_ix_done` in T+34; REMU same operands → 2.
- REM −7 % 2 → 0xFFFFFFFF; DIV −7 / 2 → 0xFFFFFFFD (truncate toward zero).
- DIV 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5. Result at T+34, or at T+1 with `DIV_EARLY_OUT_EN`.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- `wb_do_branch` at T+10 → no `div_wb_valid`, no done pulse. A new DIVU 9 / 3 at T+12 → 3.
- `wb_div_ready` low for T+34..T+36 → `div_wb_inf` stable and no done pulse. Ready at T+37 → `div_ix_done` single pulse in T+37.
